cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Blocking miss-handling controller for the set-associative `cache` array. It accepts word read requests from a single CPU-side requester and probes the array. On a hit it returns the word. On a miss it fetches the block from memory as a burst of word beats, installs it with a write command, reports any victim address, and answers from the refilled line.

## Interface
Parameters:
- Addr_Width, 32, word address width; all addresses are word addresses.
- Word_Width, 32, bits per word.
- Block_Words, 8, words per cache block; power of two, ≥2.
- Offset_Width, $clog2(Block_Words), word-offset bits, derived.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  CPU read request valid.
- req_ready_o  out  1  controller can accept a request.
- req_addr_i  in  Addr_Width  requested word address.
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
- rsp_data_o  out  Word_Width  response word.
- cache_cmd_o  out  2  array command: 00 none, 01 write, 10 read.
- cache_addr_o  out  Addr_Width  array address.
- cache_data_o  out  Word_Width*Block_Words  refill block, word k at bits [k*Word_Width +: Word_Width].
- cache_hit_i  in  1  array hit (combinational from cache_cmd_o/cache_addr_o).
- cache_data_i  in  Word_Width  array read word.
- cache_evict_i  in  1  array reports a victim during a write.
- cache_evict_addr_i  in  Addr_Width  victim address.
- mem_req_valid_o  out  1  memory burst request valid.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_req_addr_o  out  Addr_Width  block-aligned burst address.
- mem_rsp_valid_i  in  1  memory beat valid.
- mem_rsp_data_i  in  Word_Width  beat data, ascending word order.
- evict_valid_o  out  1  one-cycle victim report.
- evict_addr_o  out  Addr_Width  victim address.
- hit_count_o  out  32  hit counter (see Configuration).
- miss_count_o  out  32  miss counter (see Configuration).

## Operation
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, FILL.
- IDLE: req_ready_o=1. On req_valid_i: latch req_addr_i into addr_q and go to LOOKUP. All other states drive req_ready_o=0; only one request is outstanding.
- LOOKUP:
  - cache_cmd_o=10, cache_addr_o=addr_q.
  - Hit: register cache_data_i into rsp_data_o, pulse rsp_valid_o, go to IDLE.
  - Miss: go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid_o=1, mem_req_addr_o = addr_q with the low Offset_Width bits cleared.
  - The request is held stable until mem_req_ready_i; then clear beat_q and go to REFILL.
- REFILL: each mem_rsp_valid_i writes mem_rsp_data_i into line_q[beat_q] and increments beat_q. The beat with beat_q==Block_Words-1 moves the FSM to FILL.
- FILL, one cycle:
  - cache_cmd_o=01, cache_addr_o=addr_q, cache_data_o=line_q.
  - Register line_q[addr_q offset] into rsp_data_o and pulse rsp_valid_o.
  - If cache_evict_i=1, register cache_evict_addr_i into evict_addr_o and pulse evict_valid_o.
  - Go to IDLE.
- mem_rsp_valid_i outside REFILL is ignored.
- Outside LOOKUP and FILL, cache_cmd_o=00 and cache_addr_o=addr_q.
- beat_q is Offset_Width bits wide and wraps naturally after the final beat.
- Reset values: FSM=IDLE, req_ready_o=1 (combinational from IDLE), rsp_valid_o=0, rsp_data_o=0, cache_cmd_o=00, cache_addr_o=0, cache_data_o=0, mem_req_valid_o=0, mem_req_addr_o=0, evict_valid_o=0, evict_addr_o=0, hit_count_o=0, miss_count_o=0.
- Reset mid-operation aborts any request or burst with no response. Beats arriving after reset are ignored.

## Timing
- Request handshake at edge N (req_valid_i && req_ready_o).
- Hit path:
  - LOOKUP during cycle N+1.
  - rsp_valid_o high in cycle N+2.
  - req_ready_o high again in cycle N+2; a back-to-back request may be accepted at the end of N+2.
- Miss path:
  - mem_req_valid_o first asserted in cycle N+2.
  - With the grant at edge G and the last beat at edge L, FILL occurs in cycle L+1.
  - rsp_valid_o and evict_valid_o appear in cycle L+2, together with req_ready_o.
- Minimum miss latency: Block_Words+4 cycles from accept to response, assuming zero-wait grant and back-to-back beats.
- rsp_valid_o and evict_valid_o are registered, single-cycle pulses.

## Configuration
- CACHE_CTRL_STATS_EN defined: hit_count_o increments on each LOOKUP hit and miss_count_o on each LOOKUP miss. Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Not defined: no counter flops; hit_count_o and miss_count_o are tied to 0.

## Test plan
- Reset, then idle for 3 cycles: req_ready_o=1, all other outputs 0, cache_cmd_o=00.
- Hit:
  - Stimulus: request addr 0x40 with the array model hitting and returning 0xDEADBEEF.
  - Response: cache_cmd_o=10 for one cycle; rsp_valid_o=1 with 0xDEADBEEF exactly 2 cycles after accept; no memory request.
- Miss without eviction:
  - Stimulus: request addr 0x123 (Block_Words=8) with the array missing; grant after a 2-cycle wait; beats 0xA0..0xA7 with one idle gap.
  - Response: mem_req_addr_o=0x120; FILL drives cache_cmd_o=01 with the block; rsp_data_o=0xA3; evict_valid_o stays 0.
- Miss with eviction: same as the previous scenario with cache_evict_i=1 and victim 0x520 in FILL -> evict_valid_o pulses with evict_addr_o=0x520 in the same cycle as rsp_valid_o.
- Stray beats and reset mid-burst:
  - Stimulus: mem_rsp_valid_i asserted in IDLE; then rst_ni asserted after 3 beats of a refill.
  - Response: stray beats are ignored; after reset the FSM is IDLE with no response.
  - A new miss then refills all 8 beats correctly.
- With CACHE_CTRL_STATS_EN: 3 hits and 2 misses -> hit_count_o=3, miss_count_o=2. Without the macro both read 0.

Source files
------------

// File: rtl/cache_ctrl.sv
// Blocking miss controller: hit answers 2 cycles after accept, miss answers Block_Words+4 cycles or more.
// One request outstanding (req_ready_o low while busy); optional hit/miss counters under CACHE_CTRL_STATS_EN.
module cache_ctrl #(
  parameter int Addr_Width   = 32,
  parameter int Word_Width   = 32,
  parameter int Block_Words  = 8,
  parameter int Offset_Width = $clog2(Block_Words)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [Addr_Width-1:0]             req_addr_i,
  output logic                              rsp_valid_o,
  output logic [Word_Width-1:0]             rsp_data_o,
  output logic [1:0]                        cache_cmd_o,
  output logic [Addr_Width-1:0]             cache_addr_o,
  output logic [Word_Width*Block_Words-1:0] cache_data_o,
  input  logic                              cache_hit_i,
  input  logic [Word_Width-1:0]             cache_data_i,
  input  logic                              cache_evict_i,
  input  logic [Addr_Width-1:0]             cache_evict_addr_i,
  output logic                              mem_req_valid_o,
  input  logic                              mem_req_ready_i,
  output logic [Addr_Width-1:0]             mem_req_addr_o,
  input  logic                              mem_rsp_valid_i,
  input  logic [Word_Width-1:0]             mem_rsp_data_i,
  output logic                              evict_valid_o,
  output logic [Addr_Width-1:0]             evict_addr_o,
  output logic [31:0]                       hit_count_o,
  output logic [31:0]                       miss_count_o
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, FILL} state_t;

  state_t                         state, state_nx;
  logic [Addr_Width-1:0]          addr_q;
  logic [Offset_Width-1:0]        beat_q;
  logic [Word_Width-1:0]          line_q [Block_Words];
  logic [Word_Width*Block_Words-1:0] line_flat;
  logic [Offset_Width-1:0]        offset;

  assign offset       = addr_q[Offset_Width-1:0];
  assign cache_addr_o = addr_q;

  for (genvar k = 0; k < Block_Words; k++) begin : g_flat
    assign line_flat[k*Word_Width +: Word_Width] = line_q[k];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    req_ready_o     = 1'b0;
    cache_cmd_o     = 2'b00;
    cache_data_o    = '0;
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nx = LOOKUP;
      end
      LOOKUP: begin
        cache_cmd_o = 2'b10;
        state_nx    = cache_hit_i ? IDLE : MISS_REQ;
      end
      MISS_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = addr_q & ~Addr_Width'(Block_Words - 1);
        if (mem_req_ready_i) state_nx = REFILL;
      end
      REFILL: begin
        if (mem_rsp_valid_i && beat_q == Offset_Width'(Block_Words - 1)) state_nx = FILL;
      end
      FILL: begin
        cache_cmd_o  = 2'b01;
        cache_data_o = line_flat;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q        <= '0;
      beat_q        <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= '0;
      evict_valid_o <= 1'b0;
      evict_addr_o  <= '0;
    end else begin
      rsp_valid_o   <= 1'b0;
      evict_valid_o <= 1'b0;
      if (state == IDLE && req_valid_i) addr_q <= req_addr_i;
      if (state == LOOKUP && cache_hit_i) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o  <= cache_data_i;
      end
      if (state == MISS_REQ && mem_req_ready_i) beat_q <= '0;
      if (state == REFILL && mem_rsp_valid_i) beat_q <= beat_q + 1'b1;
      if (state == FILL) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o  <= line_q[offset];
        if (cache_evict_i) begin
          evict_valid_o <= 1'b1;
          evict_addr_o  <= cache_evict_addr_i;
        end
      end
    end
  end

  // Line buffer is only observed after a full refill, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (state == REFILL && mem_rsp_valid_i) line_q[beat_q] <= mem_rsp_data_i;
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (cache_hit_i && hit_cnt != 32'hFFFF_FFFF)   hit_cnt  <= hit_cnt + 32'd1;
      if (!cache_hit_i && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
    end
  end
  assign hit_count_o  = hit_cnt;
  assign miss_count_o = miss_cnt;
`else
  assign hit_count_o  = 32'd0;
  assign miss_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed table, reset/stray-beat sequences, random traffic against a dictionary cache model.
module tb_cache_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic [1:0]   cache_cmd;
  logic [31:0]  cache_addr;
  logic [255:0] cache_data;
  logic         cache_hit;
  logic [31:0]  cache_rdata;
  logic         cache_evict;
  logic [31:0]  cache_evict_addr;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_data;
  logic         evict_valid;
  logic [31:0]  evict_addr;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  logic         tb_hit, tb_evict;
  logic [31:0]  tb_addr, tb_word, tb_evict_addr;

  int passed = 0;
  int total  = 0;
  int n_hit  = 0;
  int n_miss = 0;

  bit [31:0] cword   [bit [31:0]];
  bit        present [bit [31:0]];

  always #5 clk = ~clk;

  // Array model: answers combinationally to the command and address on its port.
  assign cache_hit        = (cache_cmd == 2'b10) && tb_hit && (cache_addr == tb_addr);
  assign cache_rdata      = (cache_cmd == 2'b10) ? tb_word : 32'd0;
  assign cache_evict      = (cache_cmd == 2'b01) && tb_evict;
  assign cache_evict_addr = tb_evict_addr;

  cache_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .cache_cmd_o(cache_cmd), .cache_addr_o(cache_addr), .cache_data_o(cache_data),
    .cache_hit_i(cache_hit), .cache_data_i(cache_rdata),
    .cache_evict_i(cache_evict), .cache_evict_addr_i(cache_evict_addr),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_req_addr_o(mem_req_addr),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .evict_valid_o(evict_valid), .evict_addr_o(evict_addr),
    .hit_count_o(hit_count), .miss_count_o(miss_count)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic chk_stats(input string nm);
`ifdef CACHE_CTRL_STATS_EN
    chk({nm, "_hits"}, hit_count, n_hit);
    chk({nm, "_misses"}, miss_count, n_miss);
`else
    chk({nm, "_hits"}, hit_count, 0);
    chk({nm, "_misses"}, miss_count, 0);
`endif
  endtask

  // One full request; gap = beat index preceded by one idle cycle (>=8 means none).
  task automatic run_req(input logic [31:0] addr, input bit hit, input logic [31:0] exp,
                         input logic [31:0] base, input int wt, input int gap,
                         input bit ev, input logic [31:0] victim);
    logic [31:0]  blk;
    logic [255:0] blkdat;
    blk = addr & ~32'h7;
    for (int k = 0; k < 8; k++) blkdat[k*32 +: 32] = base + k;
    chk("idle_ready", req_ready, 1);
    req_valid = 1; req_addr = addr;
    tb_addr = addr; tb_hit = hit; tb_word = exp; tb_evict = ev; tb_evict_addr = victim;
    @(negedge clk);
    req_valid = 0;
    chk("lookup_cmd", cache_cmd, 2'b10);
    chk("lookup_addr", cache_addr, addr);
    chk("lookup_ready", req_ready, 0);
    if (hit) begin
      n_hit++;
      @(negedge clk);
      chk("hit_rsp_valid", rsp_valid, 1);
      chk("hit_rsp_data", rsp_data, exp);
      chk("hit_no_memreq", mem_req_valid, 0);
      chk("hit_ready", req_ready, 1);
    end else begin
      n_miss++;
      @(negedge clk);
      chk("memreq_valid", mem_req_valid, 1);
      chk("memreq_addr", mem_req_addr, blk);
      repeat (wt) @(negedge clk);
      if (wt > 0) begin
        chk("memreq_held", mem_req_valid, 1);
        chk("memreq_addr_held", mem_req_addr, blk);
      end
      mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0;
      chk("memreq_dropped", mem_req_valid, 0);
      for (int k = 0; k < 8; k++) begin
        if (k == gap) begin
          mem_rsp_valid = 0;
          @(negedge clk);
        end
        mem_rsp_valid = 1; mem_rsp_data = base + k;
        @(negedge clk);
      end
      mem_rsp_valid = 0;
      chk("fill_cmd", cache_cmd, 2'b01);
      chk("fill_addr", cache_addr, addr);
      chk("fill_data", cache_data, blkdat);
      chk("fill_no_rsp", rsp_valid, 0);
      @(negedge clk);
      chk("miss_rsp_valid", rsp_valid, 1);
      chk("miss_rsp_data", rsp_data, exp);
      chk("miss_evict_valid", evict_valid, ev);
      if (ev) chk("miss_evict_addr", evict_addr, victim);
      chk("miss_ready", req_ready, 1);
      present[blk] = 1;
      for (int k = 0; k < 8; k++) cword[blk + k] = base + k;
    end
    @(negedge clk);
    chk("rsp_pulse_end", rsp_valid, 0);
    chk("evict_pulse_end", evict_valid, 0);
  endtask

  typedef struct {
    logic [31:0] addr; bit flush; bit hit; logic [31:0] data; logic [31:0] base;
    int wt; int gap; bit ev; logic [31:0] victim;
  } vec_t;
  vec_t tbl [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, blk, base;
    bit          h;
    rst_n = 0; req_valid = 0; req_addr = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    tb_hit = 0; tb_evict = 0; tb_addr = 0; tb_word = 0; tb_evict_addr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);   chk("rst_rsp_data", rsp_data, 0);
    chk("rst_cache_addr", cache_addr, 0); chk("rst_cache_data", cache_data, 0);
    chk("rst_memreq_valid", mem_req_valid, 0); chk("rst_memreq_addr", mem_req_addr, 0);
    chk("rst_evict_valid", evict_valid, 0);    chk("rst_evict_addr", evict_addr, 0);
    chk("rst_hits", hit_count, 0);             chk("rst_misses", miss_count, 0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", req_ready, 1);
      chk("rst_cmd", cache_cmd, 0);
      @(negedge clk);
    end

    present[32'h40] = 1;
    cword[32'h40]   = 32'hDEADBEEF;
    tbl[0] = '{32'h40,  0, 1, 32'hDEADBEEF, 32'h0,  0, 8, 0, 32'h0};
    tbl[1] = '{32'h123, 0, 0, 32'hA3,       32'hA0, 2, 3, 0, 32'h0};
    tbl[2] = '{32'h123, 0, 1, 32'hA3,       32'h0,  0, 8, 0, 32'h0};
    tbl[3] = '{32'h123, 1, 0, 32'hA3,       32'hA0, 2, 5, 1, 32'h520};
    tbl[4] = '{32'h127, 0, 1, 32'hA7,       32'h0,  0, 8, 0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].flush) present.delete(tbl[i].addr & ~32'h7);
      run_req(tbl[i].addr, tbl[i].hit, tbl[i].data, tbl[i].base,
              tbl[i].wt, tbl[i].gap, tbl[i].ev, tbl[i].victim);
    end
    chk_stats("table");

    mem_rsp_valid = 1; mem_rsp_data = 32'hBAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_ready", req_ready, 1);
      chk("stray_cmd", cache_cmd, 0);
      chk("stray_rsp", rsp_valid, 0);
    end
    mem_rsp_valid = 0;

    req_valid = 1; req_addr = 32'h305; tb_hit = 0; tb_addr = 32'h305;
    @(negedge clk); req_valid = 0;
    @(negedge clk); mem_req_ready = 1;
    @(negedge clk); mem_req_ready = 0;
    for (int k = 0; k < 3; k++) begin
      mem_rsp_valid = 1; mem_rsp_data = 32'h900 + k;
      @(negedge clk);
    end
    rst_n = 0;
    #1;
    chk("abort_ready", req_ready, 1);
    chk("abort_cmd", cache_cmd, 0);
    chk("abort_memreq", mem_req_valid, 0);
    chk("abort_rsp", rsp_valid, 0);
    n_hit = 0; n_miss = 0;
    chk_stats("abort");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rsp", rsp_valid, 0);
      chk("post_rst_cmd", cache_cmd, 0);
      chk("post_rst_ready", req_ready, 1);
    end
    mem_rsp_valid = 0;
    run_req(32'h305, 0, 32'h705, 32'h700, 0, 8, 0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      a    = {25'd0, 7'($urandom_range(0, 127))};
      blk  = a & ~32'h7;
      h    = present.exists(blk);
      base = $urandom;
      run_req(a, h, h ? cword[a] : base + {29'd0, a[2:0]}, base,
              $urandom_range(0, 2), $urandom_range(0, 9), 1'($urandom_range(0, 1)), $urandom);
    end
    chk_stats("random");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
